// File: rtl/gh_pipe_reg_ce.sv
// Valid/ready pipeline register chain with bubble collapsing, clock enable and flush.
// Define GH_PIPE_REG_SKID_EN to add a one-entry skid buffer that registers in_ready.
module gh_pipe_reg_ce #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int OCC_W = $clog2(DEPTH + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    logic [DEPTH-1:0] v_q, v_d;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             step;
    logic             in_acc;
    logic             out_acc;
    logic             src_v;
    logic [WIDTH-1:0] src_d;
`ifdef GH_PIPE_REG_SKID_EN
    logic             sv_q, sv_d;
    logic [WIDTH-1:0] sd_q, sd_d;
`endif

    // Advance chain walks from the output back so a stall only stops stages behind full ones.
    always_comb begin
        logic a;
        a = ~v_q[DEPTH-1] | out_ready;
        adv = '0;
        adv[DEPTH-1] = a;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            a = ~v_q[i] | a;
            adv[i] = a;
        end
    end

    assign step = ce & ~flush;

`ifdef GH_PIPE_REG_SKID_EN
    assign in_ready = step & ~sv_q;
    assign src_v    = sv_q | in_acc;
    assign src_d    = sv_q ? sd_q : in_data;
`else
    assign in_ready = step & adv[0];
    assign src_v    = in_acc;
    assign src_d    = in_data;
`endif

    assign in_acc    = in_valid & in_ready;
    assign out_acc   = v_q[DEPTH-1] & out_ready & ce;
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign occupancy = occ_q;

    always_comb begin
        v_d   = v_q;
        d_d   = d_q;
        occ_d = occ_q;
`ifdef GH_PIPE_REG_SKID_EN
        sv_d  = sv_q;
        sd_d  = sd_q;
`endif
        if (flush) begin
            v_d   = '0;
            occ_d = '0;
`ifdef GH_PIPE_REG_SKID_EN
            sv_d  = 1'b0;
`endif
        end else if (ce) begin
            if (adv[0]) begin
                v_d[0] = src_v;
                if (src_v) d_d[0] = src_d;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (adv[i]) begin
                    v_d[i] = v_q[i-1];
                    if (v_q[i-1]) d_d[i] = d_q[i-1];
                end
            end
            occ_d = occ_q + OCC_W'(in_acc) - OCC_W'(out_acc);
`ifdef GH_PIPE_REG_SKID_EN
            if (sv_q && adv[0]) sv_d = 1'b0;
            if (in_acc && !adv[0]) begin
                sv_d = 1'b1;
                sd_d = in_data;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            occ_q <= '0;
            for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
`ifdef GH_PIPE_REG_SKID_EN
            sv_q  <= 1'b0;
            sd_q  <= '0;
`endif
        end else begin
            v_q   <= v_d;
            occ_q <= occ_d;
            for (int i = 0; i < DEPTH; i++) d_q[i] <= d_d[i];
`ifdef GH_PIPE_REG_SKID_EN
            sv_q  <= sv_d;
            sd_q  <= sd_d;
`endif
        end
    end

endmodule
